// File: rtl/video_out_stage.sv
// ---------------------------------------------------------------------------
// video_out_stage
//
// Output stage between a video core and a VGA-style encoder.
//
// What it does:
//   - Generates a pixel clock enable from the system clock.
//   - Samples the core colour and timing inputs once per pixel.
//   - Registers the sync signals and the data enable.
//   - Expands each colour component to 8 bits by bit replication.
//   - Blanks the colour outputs outside the active area.
//   - Measures the active width and height of every frame.
//
// Parameters:
//   DIV  pixel clock-enable divide ratio (1..16)
//   RW   red input width (1..8)
//   GW   green input width (1..8)
//   BW   blue input width (1..8)
//
// Ports:
//   clk_sys                   system clock (the only clock)
//   reset                     synchronous, active-high reset
//   red/green/blue            core colour components, RW/GW/BW bits
//   hblank/vblank             core blanking, active-high
//   hsync/vsync               core sync, active-high
//   ce_pixel                  pixel clock enable, one cycle in every DIV
//   vga_r/vga_g/vga_b         expanded 8-bit colour, zero while blanked
//   vga_hs/vga_vs/vga_de      registered sync and data enable
//   active_w/active_h         width of the last counted line (pixels) and
//                             number of counted lines of the last frame
//   meas_valid                active_w/active_h come from a complete frame
//   frame_tick                one-cycle pulse at each vsync rising edge
// ---------------------------------------------------------------------------
module video_out_stage #(
  parameter int DIV = 2,
  parameter int RW  = 5,
  parameter int GW  = 6,
  parameter int BW  = 5
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [RW-1:0] red,
  input  logic [GW-1:0] green,
  input  logic [BW-1:0] blue,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          hsync,
  input  logic          vsync,
  output logic          ce_pixel,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic [11:0]   active_w,
  output logic [11:0]   active_h,
  output logic          meas_valid,
  output logic          frame_tick
);

  localparam int                CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]     DIV_LAST = CW'(DIV - 1);
  localparam logic [11:0]       CNT_MAX  = 12'hFFF;

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_next;

  logic [7:0]    red_exp;
  logic [7:0]    green_exp;
  logic [7:0]    blue_exp;

  logic          de;
  logic          line_end;
  logic          frame_end;

  logic [11:0]   pix_cnt;
  logic [11:0]   line_cnt;
  logic [11:0]   last_w;
  logic [11:0]   pix_tot;
  logic [11:0]   line_tot;
  logic [11:0]   last_w_tot;

  logic          prev_hblank;
  logic          prev_vsync;
  logic          frame_seen;

  // Next value of the divider. It wraps from DIV-1 back to 0, so with
  // DIV=1 it simply stays at 0.
  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // Divider and pixel enable.
  // ce_pixel is registered from the next counter value. It is therefore
  // high exactly while div_cnt sits at DIV-1. Reset forces it low, and
  // the first enable appears DIV cycles after reset is released.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt  <= '0;
      ce_pixel <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      ce_pixel <= (div_next == DIV_LAST);
    end
  end

  // Colour expansion.
  // Output bit 7-i takes input bit W-1-(i mod W). The input bits repeat
  // MSB-first until all 8 bits are filled. For W=8 this is a
  // pass-through.
  for (genvar i = 0; i < 8; i++) begin : g_expand
    assign red_exp[7-i]   = red[RW-1-(i % RW)];
    assign green_exp[7-i] = green[GW-1-(i % GW)];
    assign blue_exp[7-i]  = blue[BW-1-(i % BW)];
  end

  // Per-sample view of the measurement state.
  //
  // The current sample is counted first. Only then are line and frame
  // boundaries applied. As a result:
  //   - a pixel that is active in the closing sample still belongs to
  //     its line;
  //   - a line that closes in the same sample as a frame is included
  //     in that frame's result.
  // Edges compare against the previous sampled value of the signal.
  always_comb begin
    de         = ~(hblank | vblank);
    line_end   = hblank & ~prev_hblank;
    frame_end  = vsync & ~prev_vsync;

    pix_tot    = pix_cnt;
    if (de && (pix_cnt != CNT_MAX)) begin
      pix_tot  = pix_cnt + 12'd1;
    end

    line_tot   = line_cnt;
    last_w_tot = last_w;
    if (line_end && (pix_tot != 12'd0)) begin
      line_tot   = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 12'd1;
      last_w_tot = pix_tot;
    end
  end

  // Video outputs.
  // These update only at the end of a pixel-enable cycle and hold
  // otherwise. Colour is forced to black whenever the sampled pixel is
  // outside the active area.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vga_r  <= 8'd0;
      vga_g  <= 8'd0;
      vga_b  <= 8'd0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else if (ce_pixel) begin
      vga_r  <= de ? red_exp   : 8'd0;
      vga_g  <= de ? green_exp : 8'd0;
      vga_b  <= de ? blue_exp  : 8'd0;
      vga_hs <= hsync;
      vga_vs <= vsync;
      vga_de <= de;
    end
  end

  // Line and pixel counting.
  // The previous hblank/vsync values reset high. This prevents a level
  // that is already high from being mistaken for an edge on the first
  // sample after reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_hblank <= 1'b1;
      prev_vsync  <= 1'b1;
      pix_cnt     <= 12'd0;
    end else if (ce_pixel) begin
      prev_hblank <= hblank;
      prev_vsync  <= vsync;
      pix_cnt     <= line_end ? 12'd0 : pix_tot;
    end
  end

  // Frame bookkeeping.
  // At a frame boundary the running line count and last width are
  // published and then cleared. Otherwise they carry the per-sample
  // update.
  //
  // The first boundary after reset closes a partial frame, so
  // meas_valid is only raised from the second boundary onwards.
  // frame_tick defaults low every cycle, which keeps it to a single
  // clk_sys pulse even when DIV=1.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      line_cnt   <= 12'd0;
      last_w     <= 12'd0;
      active_w   <= 12'd0;
      active_h   <= 12'd0;
      frame_seen <= 1'b0;
      meas_valid <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (ce_pixel) begin
        if (frame_end) begin
          active_h   <= line_tot;
          active_w   <= last_w_tot;
          line_cnt   <= 12'd0;
          last_w     <= 12'd0;
          frame_tick <= 1'b1;
          frame_seen <= 1'b1;
          if (frame_seen) begin
            meas_valid <= 1'b1;
          end
        end else begin
          line_cnt <= line_tot;
          last_w   <= last_w_tot;
        end
      end
    end
  end

endmodule

// File: doc/video_out_stage.md
VIDEO_OUT_STAGE -- requirements
Module: video_out_stage

Interface
REQ-001 Parameter DIV, default 2, meaning pixel clock-enable divide ratio, legal range 1..16.
REQ-002 Parameter RW, default 5, meaning red input width, legal range 1..8.
REQ-003 Parameter GW, default 6, meaning green input width, legal range 1..8.
REQ-004 Parameter BW, default 5, meaning blue input width, legal range 1..8.
REQ-005 Port clk_sys  in  1  meaning system clock; the block has one clock.
REQ-006 Port reset  in  1  meaning reset; reset is synchronous and active-high.
REQ-007 Port red / green / blue  in  RW / GW / BW  meaning core colour components.
REQ-008 Port hblank, vblank, hsync, vsync  in  1 each  meaning core timing signals, active-high.
REQ-009 Port ce_pixel  out  1  meaning pixel clock enable.
REQ-010 Port vga_r, vga_g, vga_b  out  8 each  meaning expanded colour.
REQ-011 Port vga_hs, vga_vs, vga_de  out  1 each  meaning registered sync and data enable.
REQ-012 Port active_w, active_h  out  12 each  meaning measured active width in pixels and height in lines.
REQ-013 Port meas_valid  out  1  meaning active_w and active_h hold a completed-frame measurement.
REQ-014 Port frame_tick  out  1  meaning one-clk_sys pulse at each measured frame boundary.

Function
REQ-015 A divider counter runs 0..DIV-1 and wraps; ce_pixel is 1 in the cycle where the counter equals DIV-1; with DIV=1, ce_pixel is constantly 1 after reset.
REQ-016 All video inputs are sampled only in ce_pixel cycles; the outputs vga_* update on the clock edge ending that cycle, giving a latency of one ce_pixel period, and hold otherwise.
REQ-017 de = ~(hblank | vblank); vga_de <= de, vga_hs <= hsync, vga_vs <= vsync.
REQ-018 Colour expansion replicates the input bits MSB-first, cyclically, until 8 bits are filled (W=5: {c,c[4:2]}; W=6: {c,c[5:4]}; W=3: {c,c,c[2:1]}; W=8: pass-through).
REQ-019 When de=0 in the sampled cycle, vga_r, vga_g and vga_b are forced to 0.
REQ-020 A 12-bit pixel counter increments for each sampled pixel with de=1 and saturates at 4095.
REQ-021 A line ends when hblank rises, sampled rising edge: the current sample has hblank=1 and the previous sample had hblank=0.
REQ-022 At line end, if the pixel count is nonzero: the line counter increments (12-bit, saturating) and the pixel count is stored as last_w. The pixel count then clears.
REQ-023 A frame ends on a sampled vsync rising edge. At frame end:
  - active_h <= line count, active_w <= last_w;
  - frame_tick=1 for exactly one clk_sys cycle;
  - the line count and last_w clear.
REQ-024 meas_valid sets at the second frame end after reset, which is the first complete frame, and stays set until reset.
REQ-025 The current sample contributes before any latch. A de=1 pixel counts toward the line that closes in the same sample. A line end in the same sample as a frame end is included in active_h and active_w.
REQ-026 The sampling of vsync and hblank edges uses the previous sampled value; the previous value resets to 1, so no edge can be detected on the first sample after reset.

Reset
REQ-027 While reset=1, at each clock the following clear to 0: the divider, ce_pixel, vga_r/g/b, vga_hs, vga_vs, vga_de, all counters, active_w, active_h, meas_valid and frame_tick.
REQ-028 Reset asserted mid-line or mid-frame discards partial counts; the first ce_pixel occurs DIV cycles after reset deasserts.

Verification
REQ-029 DIV=2, reset released -> ce_pixel pattern 0,1,0,1 starting from the first post-reset cycle; DIV=3 -> 0,0,1 repeating.
REQ-030 RW=5 with red=5'b10110 and de=1 -> vga_r=8'b10110101 one ce later; GW=6 with green=6'h3F -> vga_g=8'hFF.
REQ-031 vblank=1 while red=5'h1F -> vga_r=0 and vga_de=0 one ce later; hsync=1 -> vga_hs=1 at the same latency.
REQ-032 Two frames of 256 active pixels x 192 active lines -> after the second vsync rise: active_w=256, active_h=192, meas_valid=1, and one frame_tick per vsync rise.
REQ-033 Line of 5000 de pixels -> active_w=4095 (saturated); a frame with zero active lines -> active_h=0, active_w=0.
REQ-034 Reset pulsed mid-frame, then one full 320x200 frame and the next vsync -> meas_valid=1 only after the second post-reset vsync, active_w=320, active_h=200.
